// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard/forwarding bus between the ID stage and the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CW    = 16
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_addr;
    logic          id_is_load;
    logic          branch_taken;
    logic          stall;
    logic          flush;
    logic [SW-1:0] fwd_sel_a;
    logic [SW-1:0] fwd_sel_b;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;
    logic [CW-1:0] retire_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_addr, id_is_load, branch_taken,
        input  stall, flush, fwd_sel_a, fwd_sel_b,
               stall_count, flush_count, retire_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_addr, id_is_load, branch_taken,
        output stall, flush, fwd_sel_a, fwd_sel_b,
               stall_count, flush_count, retire_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline: tracks in-flight
// destinations after ID, picks forwarding sources, raises load-use stall and
// branch flush, and keeps saturating debug counters.
module hazard_scoreboard #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CW         = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          valid;
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic          isLoad;
    } entry_t;

    entry_t        entries [DEPTH];
    logic [SW-1:0] selA;
    logic [SW-1:0] selB;
    logic          hitA;
    logic          hitB;
    logic          hazA;
    logic          hazB;
    logic          hazard;
    logic          stallInt;
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;
    logic [CW-1:0] retireCount;

    // Register r0 is hardwired to zero, so it never creates a dependency.
    function automatic logic srcMatch(input entry_t e, input logic [AW-1:0] r,
                                      input logic used, input logic idValid);
        return e.valid && e.wrEn && (e.wrAddr == r) && (r != '0) && used && idValid;
    endfunction

    // Youngest-producer search per operand; only the youngest match decides the hazard.
    always_comb begin
        selA = '0;
        selB = '0;
        hitA = 1'b0;
        hitB = 1'b0;
        hazA = 1'b0;
        hazB = 1'b0;
        for (int s = 0; s < int'(DEPTH); s++) begin
            if (!hitA && srcMatch(entries[s], bus.id_rs, bus.id_rs_used, bus.id_valid)) begin
                hitA = 1'b1;
                selA = SW'(s + 1);
                hazA = entries[s].isLoad && (s < int'(LOAD_STAGE));
            end
            if (!hitB && srcMatch(entries[s], bus.id_rt, bus.id_rt_used, bus.id_valid)) begin
                hitB = 1'b1;
                selB = SW'(s + 1);
                hazB = entries[s].isLoad && (s < int'(LOAD_STAGE));
            end
        end
    end

    // Without forwarding every RAW dependency waits for the producer to leave; a taken branch kills ID so it never stalls.
    always_comb begin
        hazard   = (FWD_EN != 0) ? (hazA || hazB) : (hitA || hitB);
        stallInt = hazard && !bus.branch_taken;
    end

    assign bus.stall        = stallInt;
    assign bus.flush        = bus.branch_taken;
    assign bus.fwd_sel_a    = (FWD_EN != 0) ? selA : '0;
    assign bus.fwd_sel_b    = (FWD_EN != 0) ? selB : '0;
    assign bus.stall_count  = stallCount;
    assign bus.flush_count  = flushCount;
    assign bus.retire_count = retireCount;

    // Free-running shift of in-flight destinations; stalls and flushes insert a bubble at stage 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                entries[s] <= '0;
            end
        end else begin
            for (int s = 1; s < int'(DEPTH); s++) begin
                entries[s] <= entries[s-1];
            end
            if (bus.id_valid && !stallInt && !bus.branch_taken) begin
                entries[0] <= '{valid: 1'b1, wrEn: bus.id_wr_en,
                                wrAddr: bus.id_wr_addr, isLoad: bus.id_is_load};
            end else begin
                entries[0] <= '0;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount  <= '0;
            flushCount  <= '0;
            retireCount <= '0;
        end else begin
            if (stallInt && (stallCount != '1)) begin
                stallCount <= stallCount + CW'(1);
            end
            if (bus.branch_taken && (flushCount != '1)) begin
                flushCount <= flushCount + CW'(1);
            end
            if (entries[DEPTH-1].valid && (retireCount != '1)) begin
                retireCount <= retireCount + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, flush, no-forward mode,
// counter saturation and asynchronous reset.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    hazard_scoreboard_if #(.AW(5), .DEPTH(3), .CW(16)) busM ();
    hazard_scoreboard_if #(.AW(5), .DEPTH(3), .CW(16)) busN ();
    hazard_scoreboard_if #(.AW(5), .DEPTH(3), .CW(2))  busS ();

    hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(1), .CW(16)) dutM (
        .clk(clk), .reset(reset), .bus(busM.slave));
    hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(0), .CW(16)) dutN (
        .clk(clk), .reset(reset), .bus(busN.slave));
    hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(1), .CW(2)) dutS (
        .clk(clk), .reset(reset), .bus(busS.slave));

    // 10 ns clock
    always #5 clk = ~clk;

    // Same ID-stage stimulus goes to all three instances.
    task automatic drive(input int v, input int rs, input int rsU, input int rt, input int rtU,
                         input int we, input int wa, input int ld, input int br);
        busM.id_valid = 1'(v); busM.id_rs = 5'(rs); busM.id_rs_used = 1'(rsU);
        busM.id_rt = 5'(rt); busM.id_rt_used = 1'(rtU); busM.id_wr_en = 1'(we);
        busM.id_wr_addr = 5'(wa); busM.id_is_load = 1'(ld); busM.branch_taken = 1'(br);
        busN.id_valid = 1'(v); busN.id_rs = 5'(rs); busN.id_rs_used = 1'(rsU);
        busN.id_rt = 5'(rt); busN.id_rt_used = 1'(rtU); busN.id_wr_en = 1'(we);
        busN.id_wr_addr = 5'(wa); busN.id_is_load = 1'(ld); busN.branch_taken = 1'(br);
        busS.id_valid = 1'(v); busS.id_rs = 5'(rs); busS.id_rs_used = 1'(rsU);
        busS.id_rt = 5'(rt); busS.id_rt_used = 1'(rtU); busS.id_wr_en = 1'(we);
        busS.id_wr_addr = 5'(wa); busS.id_is_load = 1'(ld); busS.branch_taken = 1'(br);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 3, 1, 3, 1, 1, 4, 0, 0);
        tick();
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0d want 0", busM.stall); end
        checks++; if (busM.flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %0d want 0", busM.flush); end
        checks++; if (busM.fwd_sel_a !== 2'd0) begin fails++; $display("FAIL reset_fwd_a: got %0d want 0", busM.fwd_sel_a); end
        checks++; if (busM.stall_count !== 16'd0) begin fails++; $display("FAIL reset_stall_count: got %0d want 0", busM.stall_count); end
        checks++; if (busM.retire_count !== 16'd0) begin fails++; $display("FAIL reset_retire_count: got %0d want 0", busM.retire_count); end
        reset = 1'b0;
        nop();
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 1, 1, 2, 1, 1, 3, 0, 0);          // add r3 <= r1 + r2
        checks++; if (busM.fwd_sel_a !== 2'd0) begin fails++; $display("FAIL fwd_empty_a: got %0d want 0", busM.fwd_sel_a); end
        tick();
        drive(1, 3, 1, 5, 1, 1, 4, 0, 0);          // sub r4 <= r3 - r5
        checks++; if (busM.fwd_sel_a !== 2'd1) begin fails++; $display("FAIL fwd_stage0_a: got %0d want 1", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd0) begin fails++; $display("FAIL fwd_stage0_b: got %0d want 0", busM.fwd_sel_b); end
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL fwd_stage0_stall: got %0d want 0", busM.stall); end
        nop();
        tick();
        drive(1, 3, 1, 5, 1, 1, 4, 0, 0);
        checks++; if (busM.fwd_sel_a !== 2'd2) begin fails++; $display("FAIL fwd_stage1_a: got %0d want 2", busM.fwd_sel_a); end
        tick();
        drive(1, 4, 1, 3, 1, 0, 0, 0, 0);          // reads r4 (stage 0) and r3 (stage 2)
        checks++; if (busM.fwd_sel_a !== 2'd1) begin fails++; $display("FAIL fwd_mix_a: got %0d want 1", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd3) begin fails++; $display("FAIL fwd_mix_b: got %0d want 3", busM.fwd_sel_b); end
        tick();
        nop();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busM.retire_count !== 16'd3) begin fails++; $display("FAIL fwd_retire: got %0d want 3", busM.retire_count); end
        checks++; if (busM.stall_count !== 16'd0) begin fails++; $display("FAIL fwd_stall_count: got %0d want 0", busM.stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 1, 0, 0, 1, 3, 1, 0);          // lw r3
        tick();
        drive(1, 3, 1, 3, 1, 1, 4, 0, 0);          // add r4 <= r3 + r3
        checks++; if (busM.stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %0d want 1", busM.stall); end
        checks++; if (busM.flush !== 1'b0) begin fails++; $display("FAIL lu_flush: got %0d want 0", busM.flush); end
        tick();
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %0d want 0", busM.stall); end
        checks++; if (busM.fwd_sel_a !== 2'd2) begin fails++; $display("FAIL lu_fwd_a: got %0d want 2", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd2) begin fails++; $display("FAIL lu_fwd_b: got %0d want 2", busM.fwd_sel_b); end
        checks++; if (busM.stall_count !== 16'd1) begin fails++; $display("FAIL lu_stall_count: got %0d want 1", busM.stall_count); end
        tick();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);          // add must now sit in stage 0
        checks++; if (busM.fwd_sel_a !== 2'd1) begin fails++; $display("FAIL lu_add_issued: got %0d want 1", busM.fwd_sel_a); end
        checks++; if (busM.stall_count !== 16'd1) begin fails++; $display("FAIL lu_stall_count2: got %0d want 1", busM.stall_count); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1, 1, 1, 2, 1, 1, 3, 1, 0);          // older load of r3
        tick();
        nop();
        tick();
        drive(1, 1, 1, 2, 1, 1, 3, 0, 0);          // younger add of r3
        tick();
        drive(1, 3, 1, 3, 1, 0, 0, 0, 0);
        checks++; if (busM.fwd_sel_a !== 2'd1) begin fails++; $display("FAIL young_a: got %0d want 1", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd1) begin fails++; $display("FAIL young_b: got %0d want 1", busM.fwd_sel_b); end
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL young_stall: got %0d want 0", busM.stall); end
        drive(1, 1, 1, 0, 0, 1, 0, 1, 0);          // load to r0
        tick();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
        checks++; if (busM.fwd_sel_a !== 2'd0) begin fails++; $display("FAIL r0_a: got %0d want 0", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd0) begin fails++; $display("FAIL r0_b: got %0d want 0", busM.fwd_sel_b); end
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %0d want 0", busM.stall); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(1, 1, 1, 0, 0, 1, 3, 1, 0);          // lw r3
        tick();
        drive(1, 3, 1, 3, 1, 1, 4, 0, 1);          // load-use consumer, branch taken
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL br_stall: got %0d want 0", busM.stall); end
        checks++; if (busM.flush !== 1'b1) begin fails++; $display("FAIL br_flush: got %0d want 1", busM.flush); end
        tick();
        drive(1, 3, 1, 4, 1, 0, 0, 0, 0);          // r4 must not be in flight
        checks++; if (busM.fwd_sel_a !== 2'd2) begin fails++; $display("FAIL br_fwd_a: got %0d want 2", busM.fwd_sel_a); end
        checks++; if (busM.fwd_sel_b !== 2'd0) begin fails++; $display("FAIL br_bubble: got %0d want 0", busM.fwd_sel_b); end
        checks++; if (busM.flush_count !== 16'd1) begin fails++; $display("FAIL br_flush_count: got %0d want 1", busM.flush_count); end
        checks++; if (busM.stall_count !== 16'd0) begin fails++; $display("FAIL br_stall_count: got %0d want 0", busM.stall_count); end
    endtask

    task automatic test_no_forward();
        do_reset();
        drive(1, 1, 1, 2, 1, 1, 3, 0, 0);          // add r3
        tick();
        drive(1, 3, 1, 0, 0, 1, 4, 0, 0);          // use r3
        for (int i = 0; i < 3; i++) begin
            checks++; if (busN.stall !== 1'b1) begin fails++; $display("FAIL nf_stall_%0d: got %0d want 1", i, busN.stall); end
            checks++; if (busN.fwd_sel_a !== 2'd0) begin fails++; $display("FAIL nf_fwd_%0d: got %0d want 0", i, busN.fwd_sel_a); end
            tick();
        end
        checks++; if (busN.stall !== 1'b0) begin fails++; $display("FAIL nf_release: got %0d want 0", busN.stall); end
        checks++; if (busN.stall_count !== 16'd3) begin fails++; $display("FAIL nf_stall_count: got %0d want 3", busN.stall_count); end
        checks++; if (busN.retire_count !== 16'd1) begin fails++; $display("FAIL nf_retire1: got %0d want 1", busN.retire_count); end
        tick();
        nop();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (busN.retire_count !== 16'd2) begin fails++; $display("FAIL nf_retire2: got %0d want 2", busN.retire_count); end
    endtask

    task automatic test_saturation();
        int expCount;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 0, 1, 3, 1, 0);      // lw r3
            tick();
            drive(1, 3, 1, 0, 0, 1, 5, 0, 0);      // dependent use
            checks++; if (busS.stall !== 1'b1) begin fails++; $display("FAIL sat_stall_%0d: got %0d want 1", i, busS.stall); end
            tick();
            expCount = (i + 1 > 3) ? 3 : i + 1;
            checks++; if (busS.stall_count !== 2'(expCount)) begin fails++; $display("FAIL sat_count_%0d: got %0d want %0d", i, busS.stall_count, expCount); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);          // flush
        tick();
        drive(1, 1, 1, 0, 0, 1, 3, 1, 0);          // lw r3
        tick();
        drive(1, 3, 1, 0, 0, 1, 4, 0, 0);          // stalls once, then issues
        tick();
        tick();
        drive(1, 1, 1, 2, 1, 1, 3, 0, 0);
        tick();
        tick();
        drive(1, 1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        drive(1, 3, 1, 0, 0, 1, 6, 0, 0);
        checks++; if (busM.stall !== 1'b1) begin fails++; $display("FAIL mid_pre_stall: got %0d want 1", busM.stall); end
        checks++; if (busM.retire_count !== 16'd2) begin fails++; $display("FAIL mid_pre_retire: got %0d want 2", busM.retire_count); end
        checks++; if (busM.flush_count !== 16'd1) begin fails++; $display("FAIL mid_pre_flush: got %0d want 1", busM.flush_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busM.stall !== 1'b0) begin fails++; $display("FAIL mid_stall: got %0d want 0", busM.stall); end
        checks++; if (busM.fwd_sel_a !== 2'd0) begin fails++; $display("FAIL mid_fwd: got %0d want 0", busM.fwd_sel_a); end
        checks++; if (busM.stall_count !== 16'd0) begin fails++; $display("FAIL mid_stall_count: got %0d want 0", busM.stall_count); end
        checks++; if (busM.flush_count !== 16'd0) begin fails++; $display("FAIL mid_flush_count: got %0d want 0", busM.flush_count); end
        checks++; if (busM.retire_count !== 16'd0) begin fails++; $display("FAIL mid_retire_count: got %0d want 0", busM.retire_count); end
        reset = 1'b0;
        drive(1, 1, 1, 2, 1, 1, 3, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (busM.fwd_sel_a !== 2'd1) begin fails++; $display("FAIL mid_capture: got %0d want 1", busM.fwd_sel_a); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_branch_flush();
        test_no_forward();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- Tracks the destination register of every instruction in flight in the DEPTH stages after decode (stage 0 = EX … stage DEPTH-1 = WB).
- Produces per-operand forwarding selects, load-use stall, and branch flush for the instruction in ID.
- Keeps saturating stall, flush and retire counters for performance debug.
- Sits beside the decode stage; drives the IF/ID hold, the ID/EX bubble and the ALU operand muxes.

Parameters:
- AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (≥2).
- LOAD_STAGE, 1, first stage index whose entry can forward load data; loads in stages < LOAD_STAGE force a stall.
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard stalls until the producer leaves the table.
- CW, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register addresses.
- id_rs_used, id_rt_used  in  1  the source is actually read.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  its destination.
- id_is_load  in  1  ID instruction is a load.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID; bubble into stage 0.
- flush  out  1  kill IF and ID contents.
- fwd_sel_a, fwd_sel_b  out  SW=$clog2(DEPTH+1)  0 = register file; k = forward from the producer currently in stage k-1.
- stall_count, flush_count, retire_count  out  CW  saturating counters.

Behaviour:
- State: per stage s an entry {valid, wr_en, wr_addr, is_load}. All entries invalid after reset.
- Match: entry s matches source r when valid & wr_en & wr_addr==r & r!=0 & that source is used & id_valid. Address 0 never matches.
- Forward select: smallest matching s, so the youngest producer wins. fwd_sel = s+1; 0 if no match.
- Hazard with FWD_EN=1: the youngest match is a load with s < LOAD_STAGE. Older matches are ignored.
- Hazard with FWD_EN=0: any match. fwd_sel is forced to 0.
- stall = hazard & ~branch_taken.
- flush = branch_taken. Flush overrides stall; a killed ID instruction never stalls.
- stall, flush and fwd_sel are combinational. After reset they are 0, because the table is empty.
- Shift on every clock edge: entry[s] <= entry[s-1] for s ≥ 1.
- entry[0] <= ID fields when id_valid & ~stall & ~flush; otherwise a bubble (valid=0).
- No global enable: the pipeline never freezes stages 0..DEPTH-1. A stall only holds ID.
- stall_count increments each cycle stall=1; flush_count each cycle flush=1; retire_count each cycle entry[DEPTH-1].valid=1.
- Counters saturate at 2^CW-1; no wrap.
- Reset mid-operation: all entries are dropped immediately (asynchronous) and counters go to 0. The next edge after reset deassertion captures ID normally.
- A stalled instruction re-evaluates each cycle and issues on the first cycle with no hazard. With LOAD_STAGE=1, a load-use stall lasts exactly 1 cycle.

Test Plan:
- ID add r3<=r1+r2; next ID sub r4<=r3-r5 (rs=3) -> fwd_sel_a=1, stall=0. One cycle later, with a nop in between, fwd_sel_a=2.
- lw r3 then add r4<=r3+r3 -> stall=1 for exactly 1 cycle, stall_count=1. Then fwd_sel_a=fwd_sel_b=2 and the add enters stage 0.
- Producers of r3 in stages 0 and 2 simultaneously, consumer reads r3 -> fwd_sel_a=1 (youngest). Destination r0 -> fwd_sel=0, no stall.
- Load-use hazard while branch_taken=1 -> stall=0, flush=1, next entry[0].valid=0, flush_count increments.
- FWD_EN=0, add r3 then use r3 -> stall held 3 cycles (DEPTH) and fwd_sel=0 throughout; retire_count advances once per valid instruction.
- Reset asserted mid-stream with 3 valid entries -> immediately stall=0, fwd_sel=0, all counters 0. Set CW=2 and force 5 stalls -> stall_count holds at 3.
